// File: rtl/store_buffer.sv
// Store buffer: queues CPU stores as word-aligned, lane-encoded memory writes and drains them in order.
// Optional STBUF_SUBWORD_EN macro enables byte/half stores; otherwise only aligned word stores are legal.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [1:0]  st_size,
   output logic        mem_req,
   input  logic        mem_ack,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   output logic [4:0]  count,
   output logic        empty,
   output logic        err_misaligned
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0]   addr_q  [DEPTH];
   logic [31:0]   wdata_q [DEPTH];
   logic [3:0]    strb_q  [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [4:0]    count_q, count_d;
   logic          err_q, err_d;

   logic          legal;
   logic [31:0]   enc_wdata;
   logic [3:0]    enc_strb;
   logic          accept, push, pop;

   // Legality check and byte-lane encoding of the incoming store
   always_comb begin
      legal     = 1'b0;
      enc_wdata = st_data;
      enc_strb  = 4'b1111;
      case (st_size)
         2'b10: legal = (st_addr[1:0] == 2'b00);
`ifdef STBUF_SUBWORD_EN
         2'b00: begin
            legal     = 1'b1;
            enc_wdata = {4{st_data[7:0]}};
            enc_strb  = 4'b0001 << st_addr[1:0];
         end
         2'b01: begin
            legal     = ~st_addr[0];
            enc_wdata = {2{st_data[15:0]}};
            enc_strb  = st_addr[1] ? 4'b1100 : 4'b0011;
         end
`endif
         default: legal = 1'b0;
      endcase
   end

   assign st_ready = (count_q < 5'(DEPTH));
   assign empty    = (count_q == 5'd0);
   assign mem_req  = ~empty;
   assign count    = count_q;
   assign err_misaligned = err_q;

   assign accept = st_valid && st_ready;
   assign push   = accept && legal;
   assign pop    = mem_req && mem_ack;

   // Stale entries remain in the array after a pop, so gate the head view
   assign mem_addr  = empty ? 32'd0 : addr_q[rd_ptr_q];
   assign mem_wdata = empty ? 32'd0 : wdata_q[rd_ptr_q];
   assign mem_wstrb = empty ? 4'd0  : strb_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + {4'd0, push} - {4'd0, pop};
      err_d    = accept && !legal;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
            strb_q[i]  <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
         if (push) begin
            addr_q[wr_ptr_q]  <= {st_addr[31:2], 2'b00};
            wdata_q[wr_ptr_q] <= enc_wdata;
            strb_q[wr_ptr_q]  <= enc_strb;
         end
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle, plus directed literal checks.
module tb_store_buffer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, st_valid, st_ready, mem_req, mem_ack, empty, err_misaligned;
   logic [31:0] st_addr, st_data, mem_addr, mem_wdata;
   logic [1:0]  st_size;
   logic [3:0]  mem_wstrb;
   logic [4:0]  count;

   int errors = 0;
   int checks = 0;
   bit model_on = 1'b0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } ent_t;

   ent_t q[$];
   bit   exp_err  = 1'b0;
   bit   last_acc = 1'b0;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
      .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
      .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .count(count),
      .empty(empty), .err_misaligned(err_misaligned)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: applies the store rules to a plain queue
   task automatic model_update();
      bit   legal, acc, pop;
      ent_t e;
      if (rst) begin
         q.delete();
         exp_err  = 1'b0;
         last_acc = 1'b0;
      end else begin
         acc   = st_valid && (q.size() < DEPTH);
         pop   = mem_ack && (q.size() > 0);
         e.a   = {st_addr[31:2], 2'b00};
         e.d   = st_data;
         e.s   = 4'hF;
         legal = 1'b0;
         if (st_size == 2'b10) legal = (st_addr[1:0] == 2'b00);
`ifdef STBUF_SUBWORD_EN
         if (st_size == 2'b00) begin
            legal = 1'b1;
            e.d   = {4{st_data[7:0]}};
            e.s   = 4'b0001 << st_addr[1:0];
         end
         if (st_size == 2'b01) begin
            legal = !st_addr[0];
            e.d   = {2{st_data[15:0]}};
            e.s   = st_addr[1] ? 4'b1100 : 4'b0011;
         end
`endif
         if (pop) void'(q.pop_front());
         if (acc && legal) q.push_back(e);
         exp_err  = acc && !legal;
         last_acc = acc;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_update();
      #1;
   endtask

   always @(negedge clk) begin
      ent_t h;
      h = '0;
      if (q.size() > 0) h = q[0];
      if (model_on) begin
         check("st_ready",  32'(st_ready),       32'(q.size() < DEPTH));
         check("count",     32'(count),          32'(q.size()));
         check("empty",     32'(empty),          32'(q.size() == 0));
         check("mem_req",   32'(mem_req),        32'(q.size() != 0));
         check("mem_addr",  mem_addr,            h.a);
         check("mem_wdata", mem_wdata,           h.d);
         check("mem_wstrb", 32'(mem_wstrb),      32'(h.s));
         check("err",       32'(err_misaligned), 32'(exp_err));
      end
   end

   initial begin
      int n;
      rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = 2'b10; mem_ack = 1'b0;
      cyc();
      model_on = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(st_ready), 32'd1);
      check("rst_empty", 32'(empty),    32'd1);
      check("rst_req",   32'(mem_req),  32'd0);
      check("rst_count", 32'(count),    32'd0);

      // Aligned word store with ack held high
      st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hDEADBEEF; st_size = 2'b10; mem_ack = 1'b1;
      cyc();
      st_valid = 1'b0;
      @(negedge clk);
      check("w_req",   32'(mem_req),   32'd1);
      check("w_addr",  mem_addr,       32'h100);
      check("w_wdata", mem_wdata,      32'hDEADBEEF);
      check("w_strb",  32'(mem_wstrb), 32'hF);
      cyc();
      @(negedge clk);
      check("w_popped", 32'(count), 32'd0);

      // Misaligned half store is dropped with a single-cycle error pulse
      st_valid = 1'b1; st_addr = 32'h101; st_size = 2'b01;
      cyc();
      st_valid = 1'b0;
      @(negedge clk);
      check("h_err",   32'(err_misaligned), 32'd1);
      check("h_count", 32'(count),          32'd0);
      cyc();
      @(negedge clk);
      check("h_err_gone", 32'(err_misaligned), 32'd0);

      // Byte store at lane 3
      mem_ack = 1'b0;
      st_valid = 1'b1; st_addr = 32'h203; st_data = 32'h000000A5; st_size = 2'b00;
      cyc();
      st_valid = 1'b0;
      @(negedge clk);
`ifdef STBUF_SUBWORD_EN
      check("b_addr",  mem_addr,       32'h200);
      check("b_wdata", mem_wdata,      32'hA5A5A5A5);
      check("b_strb",  32'(mem_wstrb), 32'h8);
`else
      check("b_err",   32'(err_misaligned), 32'd1);
      check("b_count", 32'(count),          32'd0);
`endif
      mem_ack = 1'b1;
      cyc();
      cyc();
      mem_ack = 1'b0;

      // Five stores into a four-deep buffer with memory stalled
      st_size = 2'b10;
      for (int i = 0; i < 5; i++) begin
         st_valid = 1'b1; st_addr = 32'h1000 + 32'(i * 4); st_data = 32'(i + 1);
         cyc();
      end
      @(negedge clk);
      check("full_count", 32'(count),    32'd4);
      check("full_ready", 32'(st_ready), 32'd0);
      check("full_head",  mem_wdata,     32'd1);
      mem_ack = 1'b1;
      n = 0;
      do begin
         cyc();
         n++;
      end while (!last_acc && n < 10);
      check("fifth_accept", 32'(last_acc), 32'd1);
      st_valid = 1'b0;
      repeat (6) cyc();
      @(negedge clk);
      check("drained", 32'(empty), 32'd1);

      // Simultaneous push and pop at count 2 across pointer wraps
      mem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         st_valid = 1'b1; st_addr = 32'h2000 + 32'(i * 4); st_data = $urandom;
         cyc();
      end
      mem_ack = 1'b1;
      for (int i = 0; i < 10; i++) begin
         st_addr = 32'h3000 + 32'(i * 4); st_data = $urandom;
         cyc();
         @(negedge clk);
         check("pp_count", 32'(count), 32'd2);
      end
      st_valid = 1'b0;
      repeat (4) cyc();

      // Reset while holding three pending stores
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         st_valid = 1'b1; st_addr = 32'h4000 + 32'(i * 4); st_data = $urandom;
         cyc();
      end
      st_valid = 1'b0; rst = 1'b1; mem_ack = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_count", 32'(count),   32'd0);
      check("mid_rst_req",   32'(mem_req), 32'd0);
      cyc();
      @(negedge clk);
      check("ack_ignored", 32'(count), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         st_valid = ($urandom_range(0, 9) < 7);
         st_addr  = $urandom & 32'h0000_0FFF;
         st_data  = $urandom;
         st_size  = 2'($urandom_range(0, 3));
         mem_ack  = ($urandom_range(0, 1) == 1);
         rst      = ($urandom_range(0, 199) == 0);
         cyc();
      end
      rst = 1'b0; st_valid = 1'b0;
      cyc();
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
